shift_add_mult: RTL and testbench

Parametrised sequential shift-and-add multiplier with a valid/ready handshake on both sides and per-operation signed/unsigned selection. It consumes one multiplier bit per clock and returns a full-width product. It is the general-purpose multiplier for the arithmetic library, used wherever area matters more than throughput. It replaces the fixed 8x8 unsigned version with independent operand widths, two's-complement support and back-pressure.

---
 rtl/shift_add_mult.sv | 117 +++++++++++
 tb/tb_shift_add_mult.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | shift_add_mult: sequential shift-and-add multiplier, one multiplier bit per |
// | clock, valid/ready on both sides, per-operation signed/unsigned select.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module shift_add_mult #(
    parameter  int A_W = 8,
    parameter  int B_W = 8,
    localparam int P_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic           signed_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] p,
    output logic           busy
);

    localparam int                 c_cnt_w = $clog2(B_W);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(B_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [P_W-1:0]     r_a;
    logic [B_W-1:0]     r_b;
    logic [P_W-1:0]     r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_neg;
    logic [P_W-1:0]     r_p;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [A_W-1:0] w_a_mag;
    logic [B_W-1:0] w_b_mag;
    logic [P_W-1:0] w_sum;
    logic [P_W-1:0] w_res;

    // Magnitudes fit unsigned in W bits, including the most negative value.
    assign w_a_mag = (signed_mode & a[A_W-1]) ? (~a + A_W'(1)) : a;
    assign w_b_mag = (signed_mode & b[B_W-1]) ? (~b + B_W'(1)) : b;
    assign w_sum   = r_acc + (r_b[0] ? r_a : '0);
    assign w_res   = r_neg ? (~w_sum + P_W'(1)) : w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_p         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= {{B_W{1'b0}}, w_a_mag};
                        r_b        <= w_b_mag;
                        r_neg      <= signed_mode & (a[A_W-1] ^ b[B_W-1]);
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_sum;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        r_p         <= w_res;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign p         = r_p;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_shift_add_mult: scoreboard bench for shift_add_mult at 8x8, 4x12, 16x3.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_shift_add_mult;

    localparam int AWS [3] = '{8, 4, 16};
    localparam int BWS [3] = '{8, 12, 3};

    typedef struct {
        longint exp;
        longint t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv   [3];
    logic        ordy [3];
    logic [15:0] ain  [3];
    logic [11:0] bin  [3];
    logic        smd  [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        bz   [3];
    logic        ov_d [3];
    logic [18:0] pw   [3];
    logic [15:0] p0;
    logic [15:0] p1;
    logic [18:0] p2;

    longint cyc = 0;
    int     n_cmp = 0;
    int     n_err = 0;
    exp_t   sbq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign pw[0] = {3'b000, p0};
    assign pw[1] = {3'b000, p1};
    assign pw[2] = p2;

    shift_add_mult #(.A_W(8), .B_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(ain[0][7:0]), .b(bin[0][7:0]), .signed_mode(smd[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .p(p0), .busy(bz[0])
    );

    shift_add_mult #(.A_W(4), .B_W(12)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(ain[1][3:0]), .b(bin[1][11:0]), .signed_mode(smd[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .p(p1), .busy(bz[1])
    );

    shift_add_mult #(.A_W(16), .B_W(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(ain[2][15:0]), .b(bin[2][2:0]), .signed_mode(smd[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .p(p2), .busy(bz[2])
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as plain integers, multiply, wrap to P_W.
    function automatic longint ref_prod(input longint av, input longint bv,
                                        input int aw, input int bw, input bit sm);
        longint x = av & ((longint'(1) << aw) - 1);
        longint y = bv & ((longint'(1) << bw) - 1);
        if (sm && x[aw-1]) x = x - (longint'(1) << aw);
        if (sm && y[bw-1]) y = y - (longint'(1) << bw);
        return (x * y) & ((longint'(1) << (aw + bw)) - 1);
    endfunction

    // Product and latency are checked on the cycle out_valid first rises.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rst_n && ov[k] && !ov_d[k]) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("unexpected_out_dut%0d", k), 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("p_dut%0d", k), longint'(pw[k]), e.exp);
                    chk($sformatf("latency_dut%0d", k), cyc - e.t, longint'(BWS[k]));
                end
            end
            ov_d[k] <= ov[k];
        end
    end

    task automatic issue(input int k, input logic [15:0] av, input logic [11:0] bv, input bit sm);
        exp_t e;
        int   n = 0;
        while (!ir[k] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!ir[k]) chk("in_ready_timeout", 0, 1);
        ain[k] = av;
        bin[k] = bv;
        smd[k] = sm;
        iv[k]  = 1'b1;
        @(posedge clk);
        #1;
        e.exp = ref_prod(longint'(av), longint'(bv), AWS[k], BWS[k], sm);
        e.t   = cyc;
        sbq.push_back(e);
        iv[k] = 1'b0;
    endtask

    task automatic wait_ov(input int k);
        int n = 0;
        @(negedge clk);
        while (!ov[k] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!ov[k]) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic op(input int k, input logic [15:0] av, input logic [11:0] bv, input bit sm);
        issue(k, av, bv, sm);
        wait_ov(k);
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; ain[k] = '0; bin[k] = '0; smd[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_in_ready%0d", k), ir[k], 1);
            chk($sformatf("rst_out_valid%0d", k), ov[k], 0);
            chk($sformatf("rst_busy%0d", k), bz[k], 0);
            chk($sformatf("rst_p%0d", k), pw[k], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 16'd200, 12'd150, 1'b0); chk("u200x150", pw[0], 16'd30000);
        op(0, 16'hFD, 12'h07, 1'b1);   chk("s_m3x7", pw[0], 16'hFFEB);
        op(0, 16'h80, 12'h80, 1'b1);   chk("s_m128xm128", pw[0], 16'h4000);
        op(0, 16'h80, 12'h7F, 1'b1);   chk("s_m128x127", pw[0], 16'hC080);
        op(0, 16'hFF, 12'hFF, 1'b0);   chk("u_ffxff", pw[0], 16'hFE01);
        op(0, 16'hFF, 12'hFF, 1'b1);   chk("s_ffxff", pw[0], 16'h0001);
        op(0, 16'h00, 12'hA5, 1'b0);   chk("zero_a", pw[0], 0);
        op(0, 16'h5A, 12'h00, 1'b1);   chk("zero_b", pw[0], 0);

        // Back-pressure: output held, new requests ignored while busy.
        ordy[0] = 1'b0;
        issue(0, 16'd13, 12'd11, 1'b0);
        wait_ov(0);
        repeat (5) begin
            iv[0] = 1'b1; ain[0] = 16'd5; bin[0] = 12'd5;
            @(negedge clk);
            chk("bp_out_valid", ov[0], 1);
            chk("bp_p", pw[0], 143);
            chk("bp_in_ready", ir[0], 0);
            chk("bp_busy", bz[0], 1);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("rel_out_valid", ov[0], 0);
        chk("rel_in_ready", ir[0], 1);
        chk("rel_p_kept", pw[0], 143);
        op(0, 16'd6, 12'd7, 1'b0); chk("after_bp", pw[0], 42);

        // Reset during the third CALC iteration abandons the operation.
        issue(0, 16'hAB, 12'hCD, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov[0], 0);
        chk("midrst_p", pw[0], 0);
        chk("midrst_in_ready", ir[0], 1);
        chk("midrst_busy", bz[0], 0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op(0, 16'd12, 12'd12, 1'b0); chk("post_rst_12x12", pw[0], 144);

        for (int k = 1; k < 3; k++)
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < 1000; i++)
                    op(k, 16'($urandom), 12'($urandom), bit'(m));

        @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
